add_pipe: RTL
=============

ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operands a, b, sub present this cycle.
REQ-006 in_ready  output  1  pipeline accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A, two's complement.
REQ-008 b  input  WIDTH  operand B, two's complement.
REQ-009 sub  input  1  0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 s  output  WIDTH  sum/difference.
REQ-013 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 oflow  output  1  signed overflow.
REQ-015 sign  output  1  true sign of the mathematical result.

Function
REQ-016 Stage k adds bits [k*CHUNK+CHUNK-1 : k*CHUNK] with the carry registered from stage k-1; stage 0 carry-in = sub.
REQ-017 Effective B = sub ? ~b : b; inversion occurs at input capture.
REQ-018 Unprocessed upper operand slices and completed lower sum slices travel with each stage (skew registers).
REQ-019 Latency: STAGES cycles from accepted input to out_valid, with out_ready held high.
REQ-020 Throughput: one operation per cycle when out_ready=1.
REQ-021 advance = ~out_valid | out_ready; all stages shift only when advance=1; in_ready = advance.
REQ-022 Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-023 While out_valid=1 and out_ready=0, s/cout/oflow/sign hold stable; no operation lost or duplicated.
REQ-024 Bubbles (in_valid=0) propagate as invalid stages; outputs order matches input order.
REQ-025 oflow = (a[MSB] == Beff[MSB]) & (s[MSB] != a[MSB]).
REQ-026 sign = oflow ? ~s[MSB] : s[MSB].
REQ-027 CHUNK == WIDTH: single stage, latency 1.
REQ-028 WIDTH not a multiple of CHUNK, or CHUNK < 1: elaboration error.

Reset
REQ-029 reset_n=0 at a clock edge clears every stage valid bit; out_valid=0, s=0, cout=0, oflow=0, sign=0.
REQ-030 in_ready=1 during and after reset (pipeline empty).
REQ-031 Reset mid-operation discards all in-flight operations; none emerge afterward.

Configuration
REQ-032 Macro ADD_PIPE_SAT_EN defined: on oflow=1, s clamps to signed max (0x7FFF_FFFF at WIDTH=32) when sign=0, signed min (0x8000_0000) when sign=1; oflow, sign, cout report unclamped values.
REQ-033 ADD_PIPE_SAT_EN undefined: s wraps modulo 2^WIDTH; no clamp logic present.

Structure
REQ-034 Shared header add_pipe_defs.vh holds default WIDTH/CHUNK constants and the signed-max/min expressions used by saturation.
REQ-035 One sub-module full_addn (CHUNK-bit parametrised full adder: a, b, cin -> s, cout), instantiated once per stage.
REQ-036 No other sub-modules; handshake and skew registers live in add_pipe.

Verification (WIDTH=32, CHUNK=8)
REQ-037 a=0x0000_0001, b=0x0000_0002, sub=0, out_ready=1 -> after 4 cycles s=0x0000_0003, cout=0, oflow=0, sign=0.
REQ-038 a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> oflow=1, sign=0, cout=0; s=0x8000_0000 wrap, 0x7FFF_FFFF with ADD_PIPE_SAT_EN.
REQ-039 a=0x0000_0005, b=0x0000_0007, sub=1 -> s=0xFFFF_FFFE, cout=0, oflow=0, sign=1; a=0xFFFF_FFFF, b=0xFFFF_FFFF, sub=0 -> s=0xFFFF_FFFE, cout=1.
REQ-040 Back-to-back 6 ops with out_ready low cycles 5-7 -> in_ready low same cycles, outputs stable while stalled, all 6 results in order.
REQ-041 reset_n low for one cycle with 3 ops in flight -> out_valid=0 next cycle, no stale results appear in following 8 cycles.
REQ-042 Parameter sweep CHUNK in {4, 8, 16, 32} with 10k random operands vs. reference model -> zero mismatches, latency = WIDTH/CHUNK.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Package for add_pipe: default parameters and pipeline geometry helper.
package add_pipe_pkg;

`include "add_pipe_defs.vh"

  localparam int DefWidth = `ADD_PIPE_DEF_WIDTH;
  localparam int DefChunk = `ADD_PIPE_DEF_CHUNK;

  // Guarded so an illegal CHUNK reaches the elaboration check instead of dividing by zero.
  function automatic int num_stages(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

endpackage

// File: rtl/add_pipe_defs.vh
// Shared add_pipe constants: default geometry and signed saturation bounds.
`ifndef ADD_PIPE_DEFS_VH
`define ADD_PIPE_DEFS_VH

`define ADD_PIPE_DEF_WIDTH 32
`define ADD_PIPE_DEF_CHUNK 8

`define ADD_PIPE_SMAX(w) {1'b0, {((w) - 1){1'b1}}}
`define ADD_PIPE_SMIN(w) {1'b1, {((w) - 1){1'b0}}}

`endif

// File: rtl/full_addn.sv
// CHUNK-bit ripple slice used once per add_pipe stage.
module full_addn #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/add_pipe.sv
// Pipelined chunked adder/subtractor with valid/ready handshake.
// Define ADD_PIPE_SAT_EN to clamp s to the signed range on overflow.
`include "add_pipe_defs.vh"

module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = DefWidth,
  parameter int CHUNK = DefChunk
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             oflow,
  output logic             sign
);

  localparam int STAGES = num_stages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("add_pipe: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("add_pipe: WIDTH must be a multiple of CHUNK");
  end

  // Per stage: sum_q holds completed low slices, opa_q/opb_q the pending upper slices.
  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];

  logic             vld_d [STAGES];
  logic             cy_d  [STAGES];
  logic [WIDTH-1:0] opa_d [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign advance  = ~vld_q[LAST] | out_ready;
  // Reset empties the pipe, so input is accepted even while reset is held.
  assign in_ready = advance | ~reset_n;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] opa_in;
    logic [WIDTH-1:0] opb_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_nx;
    logic             vld_in;
    logic             cin_in;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;

    if (k == 0) begin : g_head
      assign vld_in = in_valid;
      assign opa_in = a;
      assign opb_in = b_eff;
      assign sum_in = '0;
      assign cin_in = sub;
    end else begin : g_body
      assign vld_in = vld_q[k-1];
      assign opa_in = opa_q[k-1];
      assign opb_in = opb_q[k-1];
      assign sum_in = sum_q[k-1];
      assign cin_in = cy_q[k-1];
    end

    full_addn #(
      .N(CHUNK)
    ) u_add (
      .a   (opa_in[k*CHUNK +: CHUNK]),
      .b   (opb_in[k*CHUNK +: CHUNK]),
      .cin (cin_in),
      .s   (chunk_s),
      .cout(chunk_c)
    );

    always_comb begin
      sum_nx = sum_in;
      sum_nx[k*CHUNK +: CHUNK] = chunk_s;
    end

    assign vld_d[k] = vld_in;
    assign cy_d[k]  = chunk_c;
    assign opa_d[k] = opa_in;
    assign opb_d[k] = opb_in;
    assign sum_d[k] = sum_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        cy_q[k]  <= cy_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  logic [WIDTH-1:0] s_raw;
  logic             a_msb;
  logic             b_msb;

  assign s_raw     = sum_q[LAST];
  assign a_msb     = opa_q[LAST][WIDTH-1];
  assign b_msb     = opb_q[LAST][WIDTH-1];
  assign out_valid = vld_q[LAST];
  assign cout      = cy_q[LAST];
  assign oflow     = (a_msb == b_msb) & (s_raw[WIDTH-1] != a_msb);
  assign sign      = oflow ? ~s_raw[WIDTH-1] : s_raw[WIDTH-1];

`ifdef ADD_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = `ADD_PIPE_SMAX(WIDTH);
  localparam logic [WIDTH-1:0] SatMin = `ADD_PIPE_SMIN(WIDTH);

  assign s = oflow ? (sign ? SatMin : SatMax) : s_raw;
`else
  assign s = s_raw;
`endif

endmodule
